// File: rtl/alu_reservation_station.sv
// Reservation station feeding the combinational ALU: buffers dispatched ops, wakes operands from
// the ALU/LSB broadcast buses, and issues the lowest-index ready entry each cycle via registered outputs.
module alu_reservation_station #(
    parameter int RS_SIZE       = 16,
    parameter int ROB_TAG_WIDTH = 4,
    parameter int OP_WIDTH      = 6,
    parameter int XLEN          = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear_in,
    input  logic                     dsp_valid_in,
    input  logic [OP_WIDTH-1:0]      dsp_op_in,
    input  logic [XLEN-1:0]          dsp_imm_in,
    input  logic [XLEN-1:0]          dsp_pc_in,
    input  logic                     dsp_qj_busy_in,
    input  logic [XLEN-1:0]          dsp_vj_in,
    input  logic [ROB_TAG_WIDTH-1:0] dsp_qj_in,
    input  logic                     dsp_qk_busy_in,
    input  logic [XLEN-1:0]          dsp_vk_in,
    input  logic [ROB_TAG_WIDTH-1:0] dsp_qk_in,
    input  logic [ROB_TAG_WIDTH-1:0] dsp_dest_in,
    output logic                     full_out,
    input  logic                     alu_cdb_valid_in,
    input  logic [ROB_TAG_WIDTH-1:0] alu_cdb_tag_in,
    input  logic [XLEN-1:0]          alu_cdb_value_in,
    input  logic                     lsb_cdb_valid_in,
    input  logic [ROB_TAG_WIDTH-1:0] lsb_cdb_tag_in,
    input  logic [XLEN-1:0]          lsb_cdb_value_in,
    output logic                     alu_valid_out,
    output logic [OP_WIDTH-1:0]      alu_op_out,
    output logic [XLEN-1:0]          alu_imm_out,
    output logic [XLEN-1:0]          alu_pc_out,
    output logic [XLEN-1:0]          alu_lhs_out,
    output logic [XLEN-1:0]          alu_rhs_out,
    output logic [ROB_TAG_WIDTH-1:0] alu_dest_out
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]       r_busy;
    logic [RS_SIZE-1:0]       r_qj_busy;
    logic [RS_SIZE-1:0]       r_qk_busy;
    logic [OP_WIDTH-1:0]      r_op   [RS_SIZE];
    logic [XLEN-1:0]          r_imm  [RS_SIZE];
    logic [XLEN-1:0]          r_pc   [RS_SIZE];
    logic [XLEN-1:0]          r_vj   [RS_SIZE];
    logic [XLEN-1:0]          r_vk   [RS_SIZE];
    logic [ROB_TAG_WIDTH-1:0] r_qj   [RS_SIZE];
    logic [ROB_TAG_WIDTH-1:0] r_qk   [RS_SIZE];
    logic [ROB_TAG_WIDTH-1:0] r_dest [RS_SIZE];

    logic [RS_SIZE-1:0] w_ready;
    logic               w_issue_hit;
    logic [IDX_W-1:0]   w_issue_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_dsp_we;
    logic [XLEN-1:0]    w_dsp_vj;
    logic [XLEN-1:0]    w_dsp_vk;
    logic               w_dsp_qj_busy;
    logic               w_dsp_qk_busy;

    assign w_ready  = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign full_out = &r_busy;
    assign w_dsp_we = dsp_valid_in && !full_out;

    // Descending scan leaves the lowest matching index as the winner.
    always_comb begin
        w_issue_hit = 1'b0;
        w_issue_idx = '0;
        w_free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_issue_hit = 1'b1;
                w_issue_idx = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_dsp_vj      = dsp_vj_in;
        w_dsp_qj_busy = dsp_qj_busy_in;
        w_dsp_vk      = dsp_vk_in;
        w_dsp_qk_busy = dsp_qk_busy_in;
        if (dsp_qj_busy_in) begin
            if (alu_cdb_valid_in && alu_cdb_tag_in == dsp_qj_in) begin
                w_dsp_vj      = alu_cdb_value_in;
                w_dsp_qj_busy = 1'b0;
            end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == dsp_qj_in) begin
                w_dsp_vj      = lsb_cdb_value_in;
                w_dsp_qj_busy = 1'b0;
            end
        end
        if (dsp_qk_busy_in) begin
            if (alu_cdb_valid_in && alu_cdb_tag_in == dsp_qk_in) begin
                w_dsp_vk      = alu_cdb_value_in;
                w_dsp_qk_busy = 1'b0;
            end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == dsp_qk_in) begin
                w_dsp_vk      = lsb_cdb_value_in;
                w_dsp_qk_busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy        <= '0;
            alu_valid_out <= 1'b0;
            alu_op_out    <= '0;
            alu_imm_out   <= '0;
            alu_pc_out    <= '0;
            alu_lhs_out   <= '0;
            alu_rhs_out   <= '0;
            alu_dest_out  <= '0;
        end else if (!rdy_in) begin
            alu_valid_out <= 1'b0;
        end else if (rob_clear_in) begin
            r_busy        <= '0;
            alu_valid_out <= 1'b0;
        end else begin
            alu_valid_out <= w_issue_hit;
            if (w_issue_hit) begin
                alu_op_out            <= r_op[w_issue_idx];
                alu_imm_out           <= r_imm[w_issue_idx];
                alu_pc_out            <= r_pc[w_issue_idx];
                alu_lhs_out           <= r_vj[w_issue_idx];
                alu_rhs_out           <= r_vk[w_issue_idx];
                alu_dest_out          <= r_dest[w_issue_idx];
                r_busy[w_issue_idx]   <= 1'b0;
            end
            // The free slot is taken from pre-issue state, so it never aliases the issuing entry.
            if (w_dsp_we) begin
                r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    // Entry payload carries no reset: it is only observed while the matching busy bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i]) begin
                    if (alu_cdb_valid_in && alu_cdb_tag_in == r_qj[i]) begin
                        r_vj[i]      <= alu_cdb_value_in;
                        r_qj_busy[i] <= 1'b0;
                    end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == r_qj[i]) begin
                        r_vj[i]      <= lsb_cdb_value_in;
                        r_qj_busy[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_busy[i]) begin
                    if (alu_cdb_valid_in && alu_cdb_tag_in == r_qk[i]) begin
                        r_vk[i]      <= alu_cdb_value_in;
                        r_qk_busy[i] <= 1'b0;
                    end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == r_qk[i]) begin
                        r_vk[i]      <= lsb_cdb_value_in;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end
            if (w_dsp_we) begin
                r_op[w_free_idx]      <= dsp_op_in;
                r_imm[w_free_idx]     <= dsp_imm_in;
                r_pc[w_free_idx]      <= dsp_pc_in;
                r_vj[w_free_idx]      <= w_dsp_vj;
                r_qj[w_free_idx]      <= dsp_qj_in;
                r_qj_busy[w_free_idx] <= w_dsp_qj_busy;
                r_vk[w_free_idx]      <= w_dsp_vk;
                r_qk[w_free_idx]      <= dsp_qk_in;
                r_qk_busy[w_free_idx] <= w_dsp_qk_busy;
                r_dest[w_free_idx]    <= dsp_dest_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus random traffic,
// all compared every cycle against an entry-list reference model.
module tb_alu_reservation_station;
    localparam int N = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear_in;
    logic        dsp_valid_in;
    logic [5:0]  dsp_op_in;
    logic [31:0] dsp_imm_in, dsp_pc_in, dsp_vj_in, dsp_vk_in;
    logic        dsp_qj_busy_in, dsp_qk_busy_in;
    logic [3:0]  dsp_qj_in, dsp_qk_in, dsp_dest_in;
    logic        full_out;
    logic        alu_cdb_valid_in, lsb_cdb_valid_in;
    logic [3:0]  alu_cdb_tag_in, lsb_cdb_tag_in;
    logic [31:0] alu_cdb_value_in, lsb_cdb_value_in;
    logic        alu_valid_out;
    logic [5:0]  alu_op_out;
    logic [31:0] alu_imm_out, alu_pc_out, alu_lhs_out, alu_rhs_out;
    logic [3:0]  alu_dest_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_in(rob_clear_in),
        .dsp_valid_in(dsp_valid_in), .dsp_op_in(dsp_op_in), .dsp_imm_in(dsp_imm_in),
        .dsp_pc_in(dsp_pc_in), .dsp_qj_busy_in(dsp_qj_busy_in), .dsp_vj_in(dsp_vj_in),
        .dsp_qj_in(dsp_qj_in), .dsp_qk_busy_in(dsp_qk_busy_in), .dsp_vk_in(dsp_vk_in),
        .dsp_qk_in(dsp_qk_in), .dsp_dest_in(dsp_dest_in), .full_out(full_out),
        .alu_cdb_valid_in(alu_cdb_valid_in), .alu_cdb_tag_in(alu_cdb_tag_in),
        .alu_cdb_value_in(alu_cdb_value_in), .lsb_cdb_valid_in(lsb_cdb_valid_in),
        .lsb_cdb_tag_in(lsb_cdb_tag_in), .lsb_cdb_value_in(lsb_cdb_value_in),
        .alu_valid_out(alu_valid_out), .alu_op_out(alu_op_out), .alu_imm_out(alu_imm_out),
        .alu_pc_out(alu_pc_out), .alu_lhs_out(alu_lhs_out), .alu_rhs_out(alu_rhs_out),
        .alu_dest_out(alu_dest_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: an unordered list of waiting ops plus the last issued op.
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] imm, pc, vj, vk;
        logic [3:0]  qj, qk, dest;
        bit          qjb, qkb;
    } ent_t;

    ent_t        m_ent[N];
    logic        m_valid;
    logic [5:0]  m_op;
    logic [31:0] m_imm, m_pc, m_lhs, m_rhs;
    logic [3:0]  m_dest;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ent[i].busy = 0;
        m_valid = 0; m_op = '0; m_imm = '0; m_pc = '0; m_lhs = '0; m_rhs = '0; m_dest = '0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_ent[i].busy) c++;
        return c;
    endfunction

    // Applies the current input values as the next rising edge would.
    task automatic model_edge();
        int iss, fre, cnt;
        ent_t e;
        if (!rst_in) begin model_reset(); return; end
        if (!rdy_in) begin m_valid = 0; return; end
        if (rob_clear_in) begin
            for (int i = 0; i < N; i++) m_ent[i].busy = 0;
            m_valid = 0;
            return;
        end
        iss = -1; fre = -1; cnt = model_count();
        for (int i = 0; i < N; i++) begin
            if (iss < 0 && m_ent[i].busy && !m_ent[i].qjb && !m_ent[i].qkb) iss = i;
            if (fre < 0 && !m_ent[i].busy) fre = i;
        end
        if (iss >= 0) begin
            m_valid = 1; m_op = m_ent[iss].op; m_imm = m_ent[iss].imm; m_pc = m_ent[iss].pc;
            m_lhs = m_ent[iss].vj; m_rhs = m_ent[iss].vk; m_dest = m_ent[iss].dest;
            m_ent[iss].busy = 0;
        end else begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_ent[i].busy && m_ent[i].qjb) begin
                if (alu_cdb_valid_in && alu_cdb_tag_in == m_ent[i].qj) begin
                    m_ent[i].vj = alu_cdb_value_in; m_ent[i].qjb = 0;
                end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == m_ent[i].qj) begin
                    m_ent[i].vj = lsb_cdb_value_in; m_ent[i].qjb = 0;
                end
            end
            if (m_ent[i].busy && m_ent[i].qkb) begin
                if (alu_cdb_valid_in && alu_cdb_tag_in == m_ent[i].qk) begin
                    m_ent[i].vk = alu_cdb_value_in; m_ent[i].qkb = 0;
                end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == m_ent[i].qk) begin
                    m_ent[i].vk = lsb_cdb_value_in; m_ent[i].qkb = 0;
                end
            end
        end
        if (dsp_valid_in && cnt < N) begin
            e.busy = 1; e.op = dsp_op_in; e.imm = dsp_imm_in; e.pc = dsp_pc_in; e.dest = dsp_dest_in;
            e.qj = dsp_qj_in; e.qk = dsp_qk_in;
            e.vj = dsp_vj_in; e.qjb = dsp_qj_busy_in;
            e.vk = dsp_vk_in; e.qkb = dsp_qk_busy_in;
            if (e.qjb && alu_cdb_valid_in && alu_cdb_tag_in == e.qj) begin e.vj = alu_cdb_value_in; e.qjb = 0; end
            else if (e.qjb && lsb_cdb_valid_in && lsb_cdb_tag_in == e.qj) begin e.vj = lsb_cdb_value_in; e.qjb = 0; end
            if (e.qkb && alu_cdb_valid_in && alu_cdb_tag_in == e.qk) begin e.vk = alu_cdb_value_in; e.qkb = 0; end
            else if (e.qkb && lsb_cdb_valid_in && lsb_cdb_tag_in == e.qk) begin e.vk = lsb_cdb_value_in; e.qkb = 0; end
            m_ent[fre] = e;
        end
    endtask

    function automatic logic [138:0] obs_vec();
        return {alu_valid_out, alu_op_out, alu_imm_out, alu_pc_out, alu_lhs_out, alu_rhs_out, alu_dest_out};
    endfunction

    function automatic logic [138:0] exp_vec();
        return {m_valid, m_op, m_imm, m_pc, m_lhs, m_rhs, m_dest};
    endfunction

    task automatic idle();
        rdy_in = 1; rob_clear_in = 0; dsp_valid_in = 0; dsp_op_in = '0; dsp_imm_in = '0; dsp_pc_in = '0;
        dsp_qj_busy_in = 0; dsp_vj_in = '0; dsp_qj_in = '0; dsp_qk_busy_in = 0; dsp_vk_in = '0;
        dsp_qk_in = '0; dsp_dest_in = '0; alu_cdb_valid_in = 0; alu_cdb_tag_in = '0;
        alu_cdb_value_in = '0; lsb_cdb_valid_in = 0; lsb_cdb_tag_in = '0; lsb_cdb_value_in = '0;
    endtask

    task automatic dsp(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                       input logic qjb, input logic [31:0] vj, input logic [3:0] qj,
                       input logic qkb, input logic [31:0] vk, input logic [3:0] qk,
                       input logic [3:0] dest);
        dsp_valid_in = 1; dsp_op_in = op; dsp_imm_in = imm; dsp_pc_in = pc;
        dsp_qj_busy_in = qjb; dsp_vj_in = vj; dsp_qj_in = qj;
        dsp_qk_busy_in = qkb; dsp_vk_in = vk; dsp_qk_in = qk; dsp_dest_in = dest;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 0; idle(); model_reset();
        cycle(); cycle();
        n_checks++;
        if (obs_vec() !== 139'd0) begin n_fail++; $display("FAIL reset_outs got=%h want=0", obs_vec()); end
        n_checks++;
        if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", full_out); end
        rst_in = 1;
        cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_release got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_ready_dispatch();
        dsp(6'h13, 32'd3, 32'h100, 0, 32'd5, 4'd0, 0, 32'd0, 4'd0, 4'd2);
        cycle(); idle();
        n_checks++;
        if (alu_valid_out !== 1'b0) begin n_fail++; $display("FAIL addi_early got=%b want=0", alu_valid_out); end
        cycle();
        n_checks++;
        if ({alu_valid_out, alu_lhs_out, alu_dest_out, alu_imm_out} !== {1'b1, 32'd5, 4'd2, 32'd3}) begin
            n_fail++;
            $display("FAIL addi_issue got v=%b lhs=%0d dest=%0d imm=%0d want v=1 lhs=5 dest=2 imm=3",
                     alu_valid_out, alu_lhs_out, alu_dest_out, alu_imm_out);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL addi_model got=%h want=%h", obs_vec(), exp_vec()); end
        cycle();
        n_checks++;
        if (alu_valid_out !== 1'b0) begin n_fail++; $display("FAIL addi_single_strobe got=%b want=0", alu_valid_out); end
    endtask

    task automatic test_alu_wakeup();
        dsp(6'h01, 32'd0, 32'h104, 1, 32'd0, 4'd7, 0, 32'd1, 4'd0, 4'd3);
        cycle(); idle();
        cycle();
        alu_cdb_valid_in = 1; alu_cdb_tag_in = 4'd7; alu_cdb_value_in = 32'h10;
        cycle(); idle();
        n_checks++;
        if (alu_valid_out !== 1'b0 || full_out !== 1'b0) begin
            n_fail++; $display("FAIL wakeup_early got v=%b full=%b want v=0 full=0", alu_valid_out, full_out);
        end
        cycle();
        n_checks++;
        if ({alu_valid_out, alu_lhs_out, alu_rhs_out, alu_dest_out} !== {1'b1, 32'h10, 32'd1, 4'd3}) begin
            n_fail++;
            $display("FAIL wakeup_issue got v=%b lhs=%h rhs=%h dest=%0d want v=1 lhs=10 rhs=1 dest=3",
                     alu_valid_out, alu_lhs_out, alu_rhs_out, alu_dest_out);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL wakeup_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_same_cycle_capture();
        dsp(6'h02, 32'd0, 32'h108, 0, 32'd9, 4'd0, 1, 32'd0, 4'd3, 4'd4);
        lsb_cdb_valid_in = 1; lsb_cdb_tag_in = 4'd3; lsb_cdb_value_in = 32'hAB;
        cycle(); idle();
        cycle();
        n_checks++;
        if ({alu_valid_out, alu_lhs_out, alu_rhs_out, alu_dest_out} !== {1'b1, 32'd9, 32'hAB, 4'd4}) begin
            n_fail++;
            $display("FAIL capture_issue got v=%b lhs=%h rhs=%h dest=%0d want v=1 lhs=9 rhs=ab dest=4",
                     alu_valid_out, alu_lhs_out, alu_rhs_out, alu_dest_out);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL capture_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_full();
        for (int i = 0; i < N; i++) begin
            dsp(6'h03, 32'(i), 32'h200 + 32'(4 * i), 1, 32'd0, 4'(i), 0, 32'd2, 4'd0, 4'(i));
            cycle();
            n_checks++;
            if (full_out !== (i == N - 1)) begin
                n_fail++; $display("FAIL fill_full idx=%0d got=%b want=%b", i, full_out, (i == N - 1));
            end
        end
        dsp(6'h04, 32'd0, 32'h300, 0, 32'd1, 4'd0, 0, 32'd1, 4'd0, 4'd15);
        cycle(); idle();
        n_checks++;
        if (full_out !== 1'b1 || alu_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL full_drop got full=%b v=%b want full=1 v=0", full_out, alu_valid_out);
        end
        alu_cdb_valid_in = 1; alu_cdb_tag_in = 4'd5; alu_cdb_value_in = 32'h55;
        cycle(); idle();
        n_checks++;
        if (full_out !== 1'b1 || alu_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL full_after_cdb got full=%b v=%b want full=1 v=0", full_out, alu_valid_out);
        end
        cycle();
        n_checks++;
        if ({full_out, alu_valid_out, alu_dest_out, alu_lhs_out} !== {1'b0, 1'b1, 4'd5, 32'h55}) begin
            n_fail++;
            $display("FAIL full_release got full=%b v=%b dest=%0d lhs=%h want full=0 v=1 dest=5 lhs=55",
                     full_out, alu_valid_out, alu_dest_out, alu_lhs_out);
        end
        cycle();
        n_checks++;
        if (alu_valid_out !== 1'b0) begin n_fail++; $display("FAIL full_dropped_issued got=%b want=0", alu_valid_out); end
        rob_clear_in = 1;
        cycle(); idle();
        n_checks++;
        if (full_out !== 1'b0) begin n_fail++; $display("FAIL full_cleanup got=%b want=0", full_out); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            dsp(6'h05, 32'd0, 32'h400, 1, 32'd0, 4'd12, 0, 32'd3, 4'd0, 4'(8 + i));
            cycle();
        end
        idle();
        alu_cdb_valid_in = 1; alu_cdb_tag_in = 4'd12; alu_cdb_value_in = 32'h77;
        cycle(); idle();
        rob_clear_in = 1;
        cycle(); idle();
        n_checks++;
        if (alu_valid_out !== 1'b0 || full_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_now got v=%b full=%b want v=0 full=0", alu_valid_out, full_out);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (alu_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_late_issue k=%0d got=%b want=0", k, alu_valid_out); end
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL flush_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 5; i++) begin
            dsp(6'h06, 32'd0, 32'h500, 1, 32'd0, 4'd14, 0, 32'd4, 4'd0, 4'(i));
            cycle();
        end
        idle();
        #2 rst_in = 0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 139'd0 || full_out !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset got=%h full=%b want=0 full=0", obs_vec(), full_out);
        end
        cycle();
        rst_in = 1;
        alu_cdb_valid_in = 1; alu_cdb_tag_in = 4'd14; alu_cdb_value_in = 32'h99;
        cycle(); idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (alu_valid_out !== 1'b0) begin n_fail++; $display("FAIL midrun_stale_issue k=%0d got=%b want=0", k, alu_valid_out); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            if (k < 6) dsp(6'h07, 32'(k), 32'h600 + 32'(k), 0, 32'(100 + k), 4'd0, 0, 32'(k), 4'd0, 4'(k));
            else idle();
            cycle();
            n_checks++;
            if (k > 0 && {alu_valid_out, alu_dest_out, alu_lhs_out} !== {1'b1, 4'(k - 1), 32'(99 + k)}) begin
                n_fail++;
                $display("FAIL b2b k=%0d got v=%b dest=%0d lhs=%0d want v=1 dest=%0d lhs=%0d",
                         k, alu_valid_out, alu_dest_out, alu_lhs_out, k - 1, 99 + k);
            end else if (k == 0 && alu_valid_out !== 1'b0) begin
                n_fail++; $display("FAIL b2b_first got=%b want=0", alu_valid_out);
            end
        end
        idle();
        cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL b2b_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy_in       = ($urandom_range(9) != 0);
            rob_clear_in = ($urandom_range(39) == 0);
            if ($urandom_range(9) < 6)
                dsp(6'($urandom), $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    1'($urandom), $urandom, 4'($urandom), 4'($urandom));
            alu_cdb_valid_in = ($urandom_range(9) < 4);
            alu_cdb_tag_in   = 4'($urandom);
            alu_cdb_value_in = $urandom;
            lsb_cdb_valid_in = ($urandom_range(9) < 4);
            lsb_cdb_tag_in   = ($urandom_range(7) == 0) ? alu_cdb_tag_in : 4'($urandom);
            lsb_cdb_value_in = $urandom;
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec() || full_out !== (model_count() == N)) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h full=%b want=%h full=%b",
                         c, obs_vec(), full_out, exp_vec(), (model_count() == N));
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ready_dispatch();
        test_alu_wakeup();
        test_same_cycle_capture();
        test_full();
        test_flush();
        test_midrun_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
